dm_ctrl: RTL

//  Parametrised multi-cycle data memory for the MIPS datapath; replaces the single-cycle word/byte DM.

---
 rtl/dm_ctrl_if.sv | 26 ++
 rtl/dm_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dm_ctrl_if.sv
// Request/response bus of the multi-cycle data memory controller.
// The MEM-stage control drives the master side; dm_ctrl sits on the slave side.
interface dm_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_sext;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_pc, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, req_pc, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dm_ctrl.sv
// Multi-cycle MIPS data memory: LB/LBU/LH/LHU/LW/SB/SH/SW over a valid/ready bus with programmable latency.
// Optional store trace enabled by defining DM_TRACE_EN.
module dm_ctrl #(
   parameter int          ADDR_W    = 12,
   parameter int          LATENCY   = 1,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic       clk,
   input  logic       reset,
   dm_ctrl_if.slave   bus
);
   localparam int DEPTH = 2 ** (ADDR_W - 2);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_t;

   state_t              state_r;
   logic [3:0]          cnt_r;
   logic                we_r;
   logic [1:0]          size_r;
   logic                sext_r;
   logic [31:0]         addr_r;
   logic [31:0]         wdata_r;
   logic                req_ready_r;
   logic                rsp_valid_r;
   logic [31:0]         rsp_rdata_r;
   logic                rsp_err_r;
   logic [31:0]         mem_r [DEPTH];

   logic [31:0]         off_s;
   logic                in_range_s;
   logic [ADDR_W-3:0]   widx_s;
   logic [1:0]          lane_s;
   logic [31:0]         cur_word_s;
   logic [7:0]          byte_s;
   logic [15:0]         half_s;
   logic                err_s;
   logic [31:0]         merged_s;
   logic [31:0]         load_s;
   logic                perform_s;

`ifdef DM_TRACE_EN
   logic [31:0]         pc_r;
`else
   logic                unused_pc_s;
   assign unused_pc_s = ^bus.req_pc;
`endif

   assign bus.req_ready = req_ready_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_rdata = rsp_rdata_r;
   assign bus.rsp_err   = rsp_err_r;

   // Address decode, error detection, lane merge and load extraction for the latched request
   always_comb begin
      off_s      = addr_r - BASE_ADDR;
      in_range_s = ({1'b0, off_s} < (33'd1 << ADDR_W));
      widx_s     = off_s[ADDR_W-1:2];
      lane_s     = off_s[1:0];
      cur_word_s = mem_r[widx_s];
      perform_s  = (state_r == WAIT) && (cnt_r == 4'd0);
      err_s      = 1'b1;
      merged_s   = cur_word_s;
      load_s     = 32'h0000_0000;
      byte_s     = 8'h00;
      half_s     = lane_s[1] ? cur_word_s[31:16] : cur_word_s[15:0];

      case (lane_s)
         2'b00:   byte_s = cur_word_s[7:0];
         2'b01:   byte_s = cur_word_s[15:8];
         2'b10:   byte_s = cur_word_s[23:16];
         2'b11:   byte_s = cur_word_s[31:24];
         default: byte_s = 8'h00;
      endcase

      case (size_r)
         2'b00: begin
            err_s = ~in_range_s;
            case (lane_s)
               2'b00:   merged_s[7:0]   = wdata_r[7:0];
               2'b01:   merged_s[15:8]  = wdata_r[7:0];
               2'b10:   merged_s[23:16] = wdata_r[7:0];
               2'b11:   merged_s[31:24] = wdata_r[7:0];
               default: merged_s        = cur_word_s;
            endcase
            load_s = sext_r ? {{24{byte_s[7]}}, byte_s} : {24'h00_0000, byte_s};
         end
         2'b01: begin
            err_s = ~in_range_s | off_s[0];
            if (lane_s[1]) begin
               merged_s[31:16] = wdata_r[15:0];
            end else begin
               merged_s[15:0] = wdata_r[15:0];
            end
            load_s = sext_r ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
         end
         2'b10: begin
            err_s    = ~in_range_s | (off_s[1:0] != 2'b00);
            merged_s = wdata_r;
            load_s   = cur_word_s;
         end
         default: begin
            err_s    = 1'b1;
            merged_s = cur_word_s;
            load_s   = 32'h0000_0000;
         end
      endcase
   end

   // Request/response FSM with registered handshake and response outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         cnt_r       <= 4'd0;
         we_r        <= 1'b0;
         size_r      <= 2'b00;
         sext_r      <= 1'b0;
         addr_r      <= 32'h0000_0000;
         wdata_r     <= 32'h0000_0000;
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 32'h0000_0000;
         rsp_err_r   <= 1'b0;
`ifdef DM_TRACE_EN
         pc_r        <= 32'h0000_0000;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.req_valid) begin
                  we_r        <= bus.req_we;
                  size_r      <= bus.req_size;
                  sext_r      <= bus.req_sext;
                  addr_r      <= bus.req_addr;
                  wdata_r     <= bus.req_wdata;
`ifdef DM_TRACE_EN
                  pc_r        <= bus.req_pc;
`endif
                  cnt_r       <= 4'(LATENCY - 1);
                  req_ready_r <= 1'b0;
                  state_r     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_r != 4'd0) begin
                  cnt_r <= cnt_r - 4'd1;
               end else begin
                  // Stores and failed accesses return zero data
                  rsp_rdata_r <= (err_s || we_r) ? 32'h0000_0000 : load_s;
                  rsp_err_r   <= err_s;
                  rsp_valid_r <= 1'b1;
                  state_r     <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  req_ready_r <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
               req_ready_r <= 1'b1;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   // Word storage: cleared on reset, written only by a committed, error-free store
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 32'h0000_0000;
         end
      end else if (perform_s && we_r && !err_s) begin
         mem_r[widx_s] <= merged_s;
`ifdef DM_TRACE_EN
         $display("@%h: *%h <= %h", pc_r, BASE_ADDR + (32'(widx_s) << 2), merged_s);
`endif
      end
   end
endmodule
